// File: rtl/revo_link_pkg.sv
// Shared constants, state encoding and pattern helper for the revolution-marker link decoder.
`timescale 1ns/1ps
package revo_link_pkg;

   localparam int unsigned WORD_W  = 8;
   localparam int unsigned WIN_W   = 2 * WORD_W;
   localparam int unsigned PHASE_W = 3;
   localparam int unsigned NUM_P   = 1 << PHASE_W;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ERR_W   = 8;
   localparam int unsigned GAP_W   = 8;

   localparam logic [WORD_W-1:0] WORD_NULL = 8'h00;
   localparam logic [WORD_W-1:0] WORD_TRG  = 8'hF0;
   localparam logic [WIN_W-1:0]  PATTERN16 = {WORD_TRG, WORD_NULL};

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2,
      SLIP    = 2'd3
   } state_t;

   // Window contents expected when the revo word starts p bits late.
   function automatic logic [WIN_W-1:0] pattern_at(input logic [PHASE_W-1:0] p);
      return PATTERN16 >> p;
   endfunction

endpackage

// File: rtl/revo_pattern_match.sv
// Combinational search of the 16-bit window for the revo pattern at any of the 8 bit offsets.
`timescale 1ns/1ps
module revo_pattern_match
   import revo_link_pkg::*;
(
   input  logic [WIN_W-1:0]   w,
   output logic               match,
   output logic [PHASE_W-1:0] p,
   output logic               nonnull
);

   // The shifted patterns are mutually distinct, so at most one offset hits.
   always_comb begin
      match   = 1'b0;
      p       = '0;
      nonnull = (w[WORD_W-1:0] != WORD_NULL);
      for (int unsigned i = 0; i < NUM_P; i++) begin
         if (w == pattern_at(PHASE_W'(i))) begin
            match = 1'b1;
            p     = PHASE_W'(i);
         end
      end
   end

endmodule

// File: rtl/revo_word_decoder.sv
// Revo-marker word decoder: finds, confirms and locks the pattern offset, emits phase-tagged triggers.
// Optional bitslip alignment enabled by defining REVO_WORD_DECODER_BITSLIP_EN.
`timescale 1ns/1ps
module revo_word_decoder
   import revo_link_pkg::*;
#(
   parameter int unsigned CONFIRM_COUNT = 4,
   parameter int unsigned MAX_ERRORS    = 3,
   parameter int unsigned BITSLIP_GAP   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [WORD_W-1:0]  word_in,
   output logic               trigger,
   output logic [PHASE_W-1:0] trigger_phase,
   output logic               locked,
   output logic [PHASE_W-1:0] offset,
   output logic [ERR_W-1:0]   error_count,
   output logic               bitslip
);

`ifdef REVO_WORD_DECODER_BITSLIP_EN
   localparam bit SLIP_EN = 1'b1;
`else
   localparam bit SLIP_EN = 1'b0;
`endif

   state_t               state_q, state_d;
   logic [WORD_W-1:0]    prev_word;
   logic                 pend_q, pend_d;
   logic [PHASE_W-1:0]   cand_q, cand_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     bad_q, bad_d;
   logic [PHASE_W-1:0]   offset_d;
   logic [PHASE_W-1:0]   slip_left_q, slip_left_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 trigger_d;
   logic [PHASE_W-1:0]   phase_d;
   logic                 locked_d;
   logic [ERR_W-1:0]     err_d;
   logic                 bitslip_d;

   logic                 match;
   logic [PHASE_W-1:0]   p;
   logic                 nonnull;
   logic                 illegal;
   logic                 do_lock;
   logic [PHASE_W-1:0]   lock_p;

   revo_pattern_match u_match (
      .w       ({prev_word, word_in}),
      .match   (match),
      .p       (p),
      .nonnull (nonnull)
   );

   // A non-null word is illegal only if neither its own cycle nor the next one matched.
   assign illegal = pend_q && !match && (state_q != SLIP);

   always_comb begin
      state_d     = state_q;
      pend_d      = nonnull && !match;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      bad_d       = bad_q;
      offset_d    = offset;
      slip_left_d = slip_left_q;
      gap_d       = gap_q;
      trigger_d   = 1'b0;
      phase_d     = '0;
      bitslip_d   = 1'b0;
      err_d       = error_count;
      do_lock     = 1'b0;
      lock_p      = '0;

      if (illegal && (error_count != {ERR_W{1'b1}})) begin
         err_d = error_count + ERR_W'(1);
      end

      case (state_q)
         HUNT: begin
            if (match) begin
               cand_d = p;
               cnt_d  = CNT_W'(1);
               if (CONFIRM_COUNT <= 1) begin
                  do_lock = 1'b1;
                  lock_p  = p;
               end else begin
                  state_d = CONFIRM;
               end
            end
         end
         CONFIRM: begin
            if (match) begin
               if (p == cand_q) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_d == CNT_W'(CONFIRM_COUNT)) begin
                     do_lock = 1'b1;
                     lock_p  = cand_q;
                  end
               end else begin
                  cand_d = p;
                  cnt_d  = CNT_W'(1);
               end
            end else if (illegal) begin
               state_d = HUNT;
            end
         end
         LOCKED: begin
            if (match && (p == offset)) begin
               trigger_d = 1'b1;
               phase_d   = p;
               bad_d     = '0;
            end else if (match || illegal) begin
               bad_d = bad_q + CNT_W'(1);
               if (bad_d == CNT_W'(MAX_ERRORS)) begin
                  state_d = HUNT;
                  bad_d   = '0;
               end
            end
         end
         SLIP: begin
            // Words arriving while the deserializer is being shifted carry no meaning.
            pend_d = 1'b0;
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else if (slip_left_q != '0) begin
               bitslip_d   = 1'b1;
               slip_left_d = slip_left_q - PHASE_W'(1);
               gap_d       = GAP_W'(BITSLIP_GAP);
            end else begin
               state_d  = HUNT;
               offset_d = '0;
            end
         end
         default: state_d = HUNT;
      endcase

      if (do_lock) begin
         offset_d = lock_p;
         bad_d    = '0;
         if (SLIP_EN && (lock_p != '0)) begin
            state_d     = SLIP;
            slip_left_d = lock_p;
            gap_d       = '0;
         end else begin
            state_d = LOCKED;
         end
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= HUNT;
         prev_word     <= '0;
         pend_q        <= 1'b0;
         cand_q        <= '0;
         cnt_q         <= '0;
         bad_q         <= '0;
         slip_left_q   <= '0;
         gap_q         <= '0;
         trigger       <= 1'b0;
         trigger_phase <= '0;
         locked        <= 1'b0;
         offset        <= '0;
         error_count   <= '0;
         bitslip       <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_word     <= word_in;
         pend_q        <= pend_d;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         bad_q         <= bad_d;
         slip_left_q   <= slip_left_d;
         gap_q         <= gap_d;
         trigger       <= trigger_d;
         trigger_phase <= phase_d;
         locked        <= locked_d;
         offset        <= offset_d;
         error_count   <= err_d;
         bitslip       <= bitslip_d;
      end
   end

endmodule

// File: doc/revo_word_decoder.md
Name: revo_word_decoder

Overview:
- Receive-side decoder for the serialized revolution-marker link.
- The transmitter sends 8-bit words MSB-first: null word 8'b00000000, and 8'b11110000 for one word per revo.
- This block sits after an 8:1 ISERDES in the word-clock domain. It finds the revo pattern at any bit offset, confirms a stable offset, and emits a phase-tagged 1-cycle trigger.
- It tracks alignment errors and drops lock on persistent errors.

Parameters:
- CONFIRM_COUNT, 4: consecutive same-offset detections needed to lock (range 1..15).
- MAX_ERRORS, 3: consecutive bad non-null words in LOCKED before returning to HUNT (range 1..15).
- BITSLIP_GAP, 4: idle word clocks between bitslip pulses (only used with the optional feature).

Ports:
- clock  in  1  word clock from the deserializer.
- reset  in  1  asynchronous, active-high; clears all state.
- word_in  in  8  deserialized word; bit 7 is the earliest bit.
- trigger  out  1  1-cycle pulse per decoded revo.
- trigger_phase  out  3  bit offset of the decoded revo (0 = aligned); valid while trigger=1.
- locked  out  1  high in the LOCKED state.
- offset  out  3  locked bit offset.
- error_count  out  8  saturating count of illegal words since reset.
- bitslip  out  1  bitslip request pulse to the ISERDES; constant 0 without the optional feature.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All outputs are 0, prev_word is 0, and the state is HUNT.
- prev_word holds the previous word_in. Window w = {prev_word, word_in}, 16 bits, prev_word in the MSBs.
- Match at offset p (0..7) when w == (16'hF000 >> p). At most one p can match in any cycle.
- Illegal word: word_in is not 8'h00 and no match occurs in this cycle or the next. The check is resolved one cycle later using a registered pending flag.
- Each illegal word increments error_count, saturating at 8'hFF.
- States:
  - HUNT:
    - On a match, store p in cand, set the confirm counter to 1, and go to CONFIRM.
    - If CONFIRM_COUNT==1, go directly to LOCKED with offset=p.
  - CONFIRM:
    - Match with p==cand: increment the counter. When it reaches CONFIRM_COUNT, load offset=cand and go to LOCKED.
    - Match with p!=cand: reload cand=p and set the counter to 1.
    - Illegal word: back to HUNT.
  - LOCKED:
    - Match with p==offset: assert trigger and trigger_phase=p on the next clock (registered output), then clear the bad counter.
    - Match with p!=offset, or an illegal word: increment the bad counter. When it reaches MAX_ERRORS, clear locked and go to HUNT.
    - In the transition cycle to HUNT, no trigger is emitted.
- Trigger latency: trigger asserts 1 clock after the cycle in which the match is seen. For p=0 the match is seen in the word after the 8'hF0 word, so trigger is 2 clocks after 8'hF0 is on word_in.
- Back-to-back revos closer than 2 words cannot be encoded by the transmitter. If one occurs, the window fails to match, and it is counted as illegal.
- Null-only stream: the state is unchanged and no errors are counted.
- trigger is never asserted outside LOCKED.

Optional Feature:
- Macro: REVO_WORD_DECODER_BITSLIP_EN.
- Defined:
  - On entry to LOCKED with offset!=0, enter state SLIP.
  - In SLIP, issue `offset` pulses on bitslip, each 1 clock wide and separated by BITSLIP_GAP idle clocks.
  - Then return to HUNT with offset cleared. The next lock is expected at p=0.
  - locked stays 0 during SLIP, and word_in is ignored in SLIP.
- Undefined: there is no SLIP state and bitslip is tied to 0. Lock is achieved at any offset, which is reported via offset and trigger_phase.

Decomposition:
- Package revo_link_pkg:
  - localparams WORD_NULL=8'h00, WORD_TRG=8'hF0, PATTERN16=16'hF000.
  - State encoding: HUNT, CONFIRM, LOCKED, SLIP.
- One sub-module, revo_pattern_match: purely combinational. Inputs w[15:0]; outputs match, p[2:0], nonnull.
- The FSM, counters and registered outputs live in the top module.

Test Plan:
- Aligned stream: nulls, then 8'hF0 every 20 words, 6 revos.
  - locked rises after the 4th revo, offset=0.
  - The 5th and 6th revos give trigger 2 clocks after 8'hF0, trigger_phase=0, error_count=0.
- Offset 3 (word pair 8'h1E,8'h00), repeated every 16 words.
  - Without the macro: locked with offset=3 and trigger_phase=3.
  - With the macro: exactly 3 bitslip pulses spaced 5 clocks apart (1 pulse + 4 idle), then HUNT.
- Candidate change: 2 revos at p=2, then revos at p=5.
  - cand reloads to 5, and lock occurs only after 4 revos at p=5.
- Errors in LOCKED: inject 8'hAA three times, separated by valid revos.
  - error_count=3 and the state stays LOCKED.
  - Then inject 3 consecutive 8'h55 words: locked drops after the 3rd and error_count=6.
- Async reset asserted mid-CONFIRM and mid-trigger pulse: all outputs go 0 immediately. After release, a fresh 4-revo confirmation is required.
- error_count saturation: 300 illegal words give error_count=8'hFF.
